arbiter_sel_unit: RTL and testbench



---
 rtl/arbiter_pkg.sv | 23 ++
 rtl/arbiter_select.sv | 90 +++++++++
 rtl/arbiter_sel_unit.sv | 73 +++++++
 tb/tb_arbiter_sel_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared order codes and grant encodings for the two-source arbiter
//
// Purpose : order-code and one-hot grant constants used by arbiter_select and
//           arbiter_sel_unit.
// Ports   : none (package).
package arbiter_pkg;

   // Arbitration order codes
   localparam logic [2:0] ORD_FIX0 = 3'b000;
   localparam logic [2:0] ORD_FIX3 = 3'b001;
   localparam logic [2:0] ORD_PRI0 = 3'b010;
   localparam logic [2:0] ORD_PRI3 = 3'b011;
   localparam logic [2:0] ORD_RR   = 3'b100;
   localparam logic [2:0] ORD_HOLD = 3'b101;
   localparam logic [2:0] ORD_CLR  = 3'b110;
   localparam logic [2:0] ORD_RSVD = 3'b111;

   // One-hot grants: bit 0 = reg_0, bit 1 = reg_3
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_R0   = 2'b01;
   localparam logic [1:0] GNT_R3   = 2'b10;

endpackage

// File: rtl/arbiter_select.sv
// rtl/arbiter_select.sv - combinational source selection for the two-source arbiter
//
// Purpose : decodes the order code into the next output data, next grant, a
//           hold request and a round-robin toggle request.
// Ports   :
//   i_order     [2:0]       arbitration order code
//   i_reg_0     [WIDTH-1:0] source 0 data
//   i_reg_3     [WIDTH-1:0] source 3 data
//   i_rr_ptr                current round-robin pointer (0 = reg_0, 1 = reg_3)
//   o_data      [WIDTH-1:0] next output data (ignored when o_hold is set)
//   o_grant     [1:0]       next one-hot grant
//   o_hold                  keep the previous output data
//   o_rr_toggle             flip the round-robin pointer
module arbiter_select
   import arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       i_order,
   input  logic [WIDTH-1:0] i_reg_0,
   input  logic [WIDTH-1:0] i_reg_3,
   input  logic             i_rr_ptr,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_grant,
   output logic             o_hold,
   output logic             o_rr_toggle
);

   logic w_r0_nz;
   logic w_r3_nz;

   assign w_r0_nz = |i_reg_0;
   assign w_r3_nz = |i_reg_3;

   always_comb begin
      // Defaults double as the clear / reserved behaviour: zero data, no grant.
      o_data      = '0;
      o_grant     = GNT_NONE;
      o_hold      = 1'b0;
      o_rr_toggle = 1'b0;
      case (i_order)
         ORD_FIX0: begin
            o_data  = i_reg_0;
            o_grant = GNT_R0;
         end
         ORD_FIX3: begin
            o_data  = i_reg_3;
            o_grant = GNT_R3;
         end
         ORD_PRI0: begin
            // Falls back to reg_3 only when reg_0 is zero and reg_3 is not;
            // both zero still grants the preferred source.
            if (w_r0_nz || !w_r3_nz) begin
               o_data  = i_reg_0;
               o_grant = GNT_R0;
            end else begin
               o_data  = i_reg_3;
               o_grant = GNT_R3;
            end
         end
         ORD_PRI3: begin
            if (w_r3_nz || !w_r0_nz) begin
               o_data  = i_reg_3;
               o_grant = GNT_R3;
            end else begin
               o_data  = i_reg_0;
               o_grant = GNT_R0;
            end
         end
         ORD_RR: begin
            o_rr_toggle = 1'b1;
            if (i_rr_ptr) begin
               o_data  = i_reg_3;
               o_grant = GNT_R3;
            end else begin
               o_data  = i_reg_0;
               o_grant = GNT_R0;
            end
         end
         ORD_HOLD: begin
            o_hold = 1'b1;
         end
         ORD_CLR, ORD_RSVD: begin
            o_data  = '0;
            o_grant = GNT_NONE;
         end
      endcase
   end

endmodule

// File: rtl/arbiter_sel_unit.sv
// rtl/arbiter_sel_unit.sv - registered two-source bus arbiter between register file and internal bus
//
// Purpose : each enabled cycle selects reg_0 or reg_3 according to the order
//           code and registers the chosen data plus a one-hot grant.
// Ports   :
//   clk                       rising-edge clock
//   rst                       asynchronous active-high reset
//   reg_0         [WIDTH-1:0] source 0 data
//   reg_3         [WIDTH-1:0] source 3 data
//   arbiter_order [2:0]       arbitration order code
//   arbiter_sel               arbitration enable
//   arbiter_out   [WIDTH-1:0] registered selected data
//   arbiter_grant [1:0]       registered one-hot grant (01 reg_0, 10 reg_3, 00 none)
module arbiter_sel_unit
   import arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] reg_0,
   input  logic [WIDTH-1:0] reg_3,
   input  logic [2:0]       arbiter_order,
   input  logic             arbiter_sel,
   output logic [WIDTH-1:0] arbiter_out,
   output logic [1:0]       arbiter_grant
);

   logic [WIDTH-1:0] r_out;
   logic [1:0]       r_grant;
   logic             r_rr_ptr;

   logic [WIDTH-1:0] w_data;
   logic [1:0]       w_grant;
   logic             w_hold;
   logic             w_rr_toggle;

   arbiter_select #(
      .WIDTH(WIDTH)
   ) u_select (
      .i_order     (arbiter_order),
      .i_reg_0     (reg_0),
      .i_reg_3     (reg_3),
      .i_rr_ptr    (r_rr_ptr),
      .o_data      (w_data),
      .o_grant     (w_grant),
      .o_hold      (w_hold),
      .o_rr_toggle (w_rr_toggle)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out    <= '0;
         r_grant  <= GNT_NONE;
         r_rr_ptr <= 1'b0;
      end else if (!arbiter_sel) begin
         // Disabled: data and pointer freeze, grant drops.
         r_grant <= GNT_NONE;
      end else begin
         if (!w_hold) begin
            r_out <= w_data;
         end
         r_grant <= w_grant;
         if (w_rr_toggle) begin
            r_rr_ptr <= ~r_rr_ptr;
         end
      end
   end

   assign arbiter_out   = r_out;
   assign arbiter_grant = r_grant;

endmodule

// File: tb/tb_arbiter_sel_unit.sv
// tb/tb_arbiter_sel_unit.sv - self-checking bench for arbiter_sel_unit
module tb_arbiter_sel_unit;

   logic       clk;
   logic       rst;
   logic [7:0] reg_0;
   logic [7:0] reg_3;
   logic [2:0] arbiter_order;
   logic       arbiter_sel;
   logic [7:0] arbiter_out;
   logic [1:0] arbiter_grant;

   int n_checks;
   int n_fail;

   typedef struct {
      logic       sel;
      logic [2:0] ord;
      logic [7:0] r0;
      logic [7:0] r3;
      logic [7:0] eout;
      logic [1:0] egnt;
   } vec_t;

   vec_t vecs[$];

   // Reference model state
   logic [7:0] m_out;
   logic [1:0] m_gnt;
   int         m_ptr;

   arbiter_sel_unit #(
      .WIDTH(8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .reg_0         (reg_0),
      .reg_3         (reg_3),
      .arbiter_order (arbiter_order),
      .arbiter_sel   (arbiter_sel),
      .arbiter_out   (arbiter_out),
      .arbiter_grant (arbiter_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] eo, input logic [1:0] eg);
      n_checks++;
      if (arbiter_out !== eo || arbiter_grant !== eg) begin
         n_fail++;
         $display("FAIL %s: out=%02h grant=%b, expected out=%02h grant=%b",
                  nm, arbiter_out, arbiter_grant, eo, eg);
      end
   endtask

   // Apply inputs just after an edge, then wait for the next edge and settle.
   task automatic step(input logic s, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      arbiter_sel   = s;
      arbiter_order = o;
      reg_0         = a;
      reg_3         = b;
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle asynchronous reset pulse; checks outputs clear with no edge.
   task automatic reset_pulse(input string nm);
      #1;
      rst = 1'b1;
      #1;
      chk(nm, 8'h00, 2'b00);
      rst = 1'b0;
      m_out = 8'h00;
      m_gnt = 2'b00;
      m_ptr = 0;
   endtask

   function automatic void add(input logic s, input logic [2:0] o, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] eo, input logic [1:0] eg);
      vec_t v;
      v.sel = s; v.ord = o; v.r0 = a; v.r3 = b; v.eout = eo; v.egnt = eg;
      vecs.push_back(v);
   endfunction

   // Behavioural reference: pick a winner index (0 = reg_0, 1 = reg_3),
   // then out = source[winner], grant = 1 << winner.
   task automatic model(input logic s, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] src [2];
      int w;
      src[0] = a;
      src[1] = b;
      w = -1;
      if (!s) begin
         m_gnt = 2'b00;
      end else begin
         case (int'(o))
            0: w = 0;
            1: w = 1;
            2: w = (a == 0 && b != 0) ? 1 : 0;
            3: w = (b == 0 && a != 0) ? 0 : 1;
            4: begin w = m_ptr; m_ptr = 1 - m_ptr; end
            5: m_gnt = 2'b00;
            default: begin m_out = 8'h00; m_gnt = 2'b00; end
         endcase
         if (w >= 0) begin
            m_out = src[w];
            m_gnt = 2'(1 << w);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0;
      reg_0 = 8'hF0;
      reg_3 = 8'h01;
      arbiter_order = 3'b000;
      arbiter_sel = 1'b0;
      m_out = 8'h00; m_gnt = 2'b00; m_ptr = 0;

      // Disabled after reset
      for (int i = 0; i < 5; i++) add(1'b0, 3'b000, 8'hF0, 8'h01, 8'h00, 2'b00);
      // Order sweep, 5 cycles per code
      for (int i = 0; i < 5; i++) add(1'b1, 3'b000, 8'hF0, 8'h01, 8'hF0, 2'b01);
      for (int i = 0; i < 5; i++) add(1'b1, 3'b001, 8'hF0, 8'h01, 8'h01, 2'b10);
      for (int i = 0; i < 5; i++) add(1'b1, 3'b010, 8'hF0, 8'h01, 8'hF0, 2'b01);
      for (int i = 0; i < 5; i++) add(1'b1, 3'b011, 8'hF0, 8'h01, 8'h01, 2'b10);
      add(1'b1, 3'b100, 8'hF0, 8'h01, 8'hF0, 2'b01);
      add(1'b1, 3'b100, 8'hF0, 8'h01, 8'h01, 2'b10);
      add(1'b1, 3'b100, 8'hF0, 8'h01, 8'hF0, 2'b01);
      add(1'b1, 3'b100, 8'hF0, 8'h01, 8'h01, 2'b10);
      add(1'b1, 3'b100, 8'hF0, 8'h01, 8'hF0, 2'b01);
      for (int i = 0; i < 5; i++) add(1'b1, 3'b101, 8'hF0, 8'h01, 8'hF0, 2'b00);
      for (int i = 0; i < 5; i++) add(1'b1, 3'b110, 8'hF0, 8'h01, 8'h00, 2'b00);
      for (int i = 0; i < 5; i++) add(1'b1, 3'b111, 8'hF0, 8'h01, 8'h00, 2'b00);
      // Priority fallback
      add(1'b1, 3'b010, 8'h00, 8'h01, 8'h01, 2'b10);
      add(1'b1, 3'b011, 8'h00, 8'h00, 8'h00, 2'b10);
      add(1'b1, 3'b010, 8'h00, 8'h00, 8'h00, 2'b01);
      add(1'b1, 3'b011, 8'hF0, 8'h00, 8'hF0, 2'b01);

      // Reset asserted mid-cycle, held across an edge
      #3;
      rst = 1'b1;
      #1;
      chk("reset_async", 8'h00, 2'b00);
      @(posedge clk);
      #1;
      chk("reset_held", 8'h00, 2'b00);
      rst = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].sel, vecs[i].ord, vecs[i].r0, vecs[i].r3);
         chk($sformatf("vec%0d_ord%0b", i, vecs[i].ord), vecs[i].eout, vecs[i].egnt);
      end

      // Round-robin pause: pointer must survive disabled cycles
      reset_pulse("rr_pause_reset");
      step(1'b1, 3'b100, 8'hF0, 8'h01); chk("rr_pause_0", 8'hF0, 2'b01);
      step(1'b1, 3'b100, 8'hF0, 8'h01); chk("rr_pause_1", 8'h01, 2'b10);
      step(1'b1, 3'b100, 8'hF0, 8'h01); chk("rr_pause_2", 8'hF0, 2'b01);
      step(1'b0, 3'b100, 8'hF0, 8'h01); chk("rr_pause_off0", 8'hF0, 2'b00);
      step(1'b0, 3'b100, 8'hF0, 8'h01); chk("rr_pause_off1", 8'hF0, 2'b00);
      step(1'b1, 3'b100, 8'hF0, 8'h01); chk("rr_pause_resume", 8'h01, 2'b10);

      // Async reset in the middle of round-robin restarts at reg_0
      step(1'b1, 3'b100, 8'hF0, 8'h01); chk("rr_mid_0", 8'hF0, 2'b01);
      reset_pulse("rr_mid_reset");
      step(1'b1, 3'b100, 8'hF0, 8'h01); chk("rr_mid_restart", 8'hF0, 2'b01);
      step(1'b1, 3'b100, 8'hF0, 8'h01); chk("rr_mid_next", 8'h01, 2'b10);

      // Randomised run against the reference model
      reset_pulse("rand_reset");
      for (int i = 0; i < 400; i++) begin
         logic       s;
         logic [2:0] o;
         logic [7:0] a;
         logic [7:0] b;
         s = ($urandom_range(0, 5) != 0);
         o = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         step(s, o, a, b);
         model(s, o, a, b);
         chk($sformatf("rand%0d", i), m_out, m_gnt);
         if ($urandom_range(0, 49) == 0) reset_pulse($sformatf("rand_rst%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
